// File: rtl/riscv_test_sequencer.sv
// On-chip test sequencer: boots each selected test slot in turn, watches the data-memory bus
// for a tohost write and grades every test as pass, fail or timeout.
module riscv_test_sequencer #(
  parameter int unsigned       N_TESTS     = 4,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       TIMEOUT_W   = 16,
  parameter logic [ADDR_W-1:0] BOOT_BASE   = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] BOOT_STRIDE = 32'h0000_0400,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 32'h0000_1000,
  parameter int unsigned       RST_HOLD    = 4,
  localparam int unsigned      ID_W        = (N_TESTS > 1) ? $clog2(N_TESTS) : 1,
  localparam int unsigned      CNT_W       = $clog2(N_TESTS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_TESTS-1:0]   test_mask,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  input  logic                 dmem_we,
  input  logic [ADDR_W-1:0]    dmem_addr,
  input  logic [DATA_W-1:0]    dmem_wdata,
  output logic                 core_rst_n,
  output logic [ADDR_W-1:0]    boot_pc,
  output logic [ID_W-1:0]      test_id,
  output logic                 busy,
  output logic                 done,
  output logic                 result_valid,
  output logic [1:0]           result_code,
  output logic [DATA_W-1:0]    result_data,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic [CNT_W-1:0]     tmo_cnt
);

  localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StHold,
    StRun,
    StReport,
    StDone
  } state_t;

  state_t               state_q;
  logic [N_TESTS-1:0]   mask_q;
  logic [TIMEOUT_W-1:0] timeout_q;
  logic [TIMEOUT_W-1:0] cyc_cnt_q;
  logic [HOLD_W-1:0]    hold_cnt_q;

  logic tohost_hit;
  logic tmo_hit;
  logic last_id;

  assign tohost_hit = dmem_we && (dmem_addr == TOHOST_ADDR);
  // A zero limit disables the timeout; the cycle counter is then free to wrap.
  assign tmo_hit    = (timeout_q != '0) && (cyc_cnt_q == timeout_q - TIMEOUT_W'(1));
  assign last_id    = (test_id == ID_W'(N_TESTS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      mask_q       <= '0;
      timeout_q    <= '0;
      cyc_cnt_q    <= '0;
      hold_cnt_q   <= '0;
      core_rst_n   <= 1'b0;
      boot_pc      <= '0;
      test_id      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      result_code  <= '0;
      result_data  <= '0;
      pass_cnt     <= '0;
      fail_cnt     <= '0;
      tmo_cnt      <= '0;
    end else begin
      result_valid <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q   <= StSelect;
            mask_q    <= test_mask;
            timeout_q <= timeout_cycles;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            tmo_cnt   <= '0;
            test_id   <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        StSelect: begin
          if (mask_q[test_id]) begin
            boot_pc    <= BOOT_BASE + BOOT_STRIDE * ADDR_W'(test_id);
            hold_cnt_q <= '0;
            state_q    <= StHold;
          end else if (last_id) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            test_id <= test_id + ID_W'(1);
          end
        end
        StHold: begin
          if (hold_cnt_q == HOLD_W'(RST_HOLD - 1)) begin
            state_q    <= StRun;
            core_rst_n <= 1'b1;
            cyc_cnt_q  <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end
        StRun: begin
          cyc_cnt_q <= cyc_cnt_q + TIMEOUT_W'(1);
          // The tohost write takes priority over a coincident timeout.
          if (tohost_hit) begin
            state_q      <= StReport;
            core_rst_n   <= 1'b0;
            result_valid <= 1'b1;
            result_data  <= dmem_wdata;
            if (dmem_wdata == DATA_W'(1)) begin
              result_code <= 2'b01;
              pass_cnt    <= pass_cnt + CNT_W'(1);
            end else begin
              result_code <= 2'b10;
              fail_cnt    <= fail_cnt + CNT_W'(1);
            end
          end else if (tmo_hit) begin
            state_q      <= StReport;
            core_rst_n   <= 1'b0;
            result_valid <= 1'b1;
            result_data  <= '0;
            result_code  <= 2'b11;
            tmo_cnt      <= tmo_cnt + CNT_W'(1);
          end
        end
        StReport: begin
          if (last_id) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            test_id <= test_id + ID_W'(1);
            state_q <= StSelect;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_test_sequencer.sv
// Bench for riscv_test_sequencer: a core stand-in writes tohost on a planned RUN cycle and a
// per-slot outcome model predicts grades, data, run lengths, boot PCs and counters.
module tb_riscv_test_sequencer;

  localparam int          N        = 4;
  localparam logic [31:0] BASE     = 32'h0000_0000;
  localparam logic [31:0] STRIDE   = 32'h0000_0400;
  localparam logic [31:0] TOHOST   = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  test_mask;
  logic [15:0] timeout_cycles;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        core_rst_n;
  logic [31:0] boot_pc;
  logic [1:0]  test_id;
  logic        busy;
  logic        done;
  logic        result_valid;
  logic [1:0]  result_code;
  logic [31:0] result_data;
  logic [2:0]  pass_cnt;
  logic [2:0]  fail_cnt;
  logic [2:0]  tmo_cnt;

  int errors = 0;
  int checks = 0;

  // Per-slot plan: RUN cycle index of the tohost write (-1 = never) and its data.
  int          wr_cyc [N];
  logic [31:0] wr_dat [N];

  riscv_test_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .test_mask      (test_mask),
    .timeout_cycles (timeout_cycles),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .core_rst_n     (core_rst_n),
    .boot_pc        (boot_pc),
    .test_id        (test_id),
    .busy           (busy),
    .done           (done),
    .result_valid   (result_valid),
    .result_code    (result_code),
    .result_data    (result_data),
    .pass_cnt       (pass_cnt),
    .fail_cnt       (fail_cnt),
    .tmo_cnt        (tmo_cnt)
  );

  always #5 clk = ~clk;

  task automatic run_campaign(input string tag, input logic [3:0] mask, input logic [15:0] tmo,
                              input int inject_at, input int budget, output int cycles);
    logic [1:0]  e_code [N];
    logic [31:0] e_data [N];
    int          e_high [N];
    int          e_id   [N];
    logic [1:0]  o_code [N];
    logic [31:0] o_data [N];
    int          o_high [N];
    int          o_id   [N];
    logic [31:0] o_pc   [N];
    logic        o_busy [N];
    int n_exp, got, high, run_idx, cur, cyc, ep, ef, et;
    bit finished;
    logic [31:0] exp_pc;
    n_exp = 0; ep = 0; ef = 0; et = 0;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        if (wr_cyc[i] >= 0 && (tmo == 0 || wr_cyc[i] < int'(tmo))) begin
          e_code[n_exp] = (wr_dat[i] == 32'd1) ? 2'b01 : 2'b10;
          e_data[n_exp] = wr_dat[i];
          e_high[n_exp] = wr_cyc[i] + 1;
          if (wr_dat[i] == 32'd1) ep++; else ef++;
        end else begin
          e_code[n_exp] = 2'b11;
          e_data[n_exp] = 32'd0;
          e_high[n_exp] = int'(tmo);
          et++;
        end
        e_id[n_exp] = i;
        n_exp++;
      end
    end

    @(negedge clk);
    test_mask = mask; timeout_cycles = tmo; start = 1'b1;
    @(negedge clk);
    got = 0; high = 0; run_idx = -1; cyc = 0; finished = 0;
    while (cyc < budget) begin
      start = 1'b0; dmem_we = 1'b0; dmem_addr = '0; dmem_wdata = '0;
      if (result_valid) begin
        if (got < N) begin
          o_code[got] = result_code; o_data[got] = result_data; o_high[got] = high;
        end
        got++; high = 0; run_idx = -1;
      end
      if (done) begin
        finished = 1;
        break;
      end
      if (core_rst_n) begin
        run_idx++; high++;
        if (run_idx == 0 && got < N) begin
          o_id[got] = int'(test_id); o_pc[got] = boot_pc; o_busy[got] = busy;
        end
        cur = int'(test_id);
        if (run_idx == wr_cyc[cur]) begin
          dmem_we = 1'b1; dmem_addr = TOHOST; dmem_wdata = wr_dat[cur];
        end else if ($urandom_range(0, 3) == 0) begin
          dmem_we = 1'b1; dmem_addr = TOHOST + 32'(4 * $urandom_range(1, 100)); dmem_wdata = 32'd1;
        end
        if (inject_at >= 0 && got == 0 && run_idx == inject_at) begin
          start = 1'b1; test_mask = 4'b1111;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; dmem_we = 1'b0;
    cycles = cyc;

    checks++;
    if (!finished) begin
      errors++; $display("FAIL %s done: not reached within %0d cycles", tag, budget);
    end
    checks++;
    if (got !== n_exp) begin
      errors++; $display("FAIL %s pulses: got %0d expected %0d", tag, got, n_exp);
    end
    for (int k = 0; k < n_exp && k < got; k++) begin
      exp_pc = BASE + STRIDE * 32'(e_id[k]);
      checks++;
      if (o_code[k] !== e_code[k]) begin
        errors++; $display("FAIL %s code[%0d]: got %b expected %b", tag, k, o_code[k], e_code[k]);
      end
      checks++;
      if (o_data[k] !== e_data[k]) begin
        errors++; $display("FAIL %s data[%0d]: got %h expected %h", tag, k, o_data[k], e_data[k]);
      end
      checks++;
      if (o_high[k] !== e_high[k]) begin
        errors++; $display("FAIL %s run_len[%0d]: got %0d expected %0d", tag, k, o_high[k], e_high[k]);
      end
      checks++;
      if (o_id[k] !== e_id[k]) begin
        errors++; $display("FAIL %s test_id[%0d]: got %0d expected %0d", tag, k, o_id[k], e_id[k]);
      end
      checks++;
      if (o_pc[k] !== exp_pc) begin
        errors++; $display("FAIL %s boot_pc[%0d]: got %h expected %h", tag, k, o_pc[k], exp_pc);
      end
      checks++;
      if (o_busy[k] !== 1'b1) begin
        errors++; $display("FAIL %s busy_in_run[%0d]: got %b expected 1", tag, k, o_busy[k]);
      end
    end
    checks++;
    if (pass_cnt !== 3'(ep) || fail_cnt !== 3'(ef) || tmo_cnt !== 3'(et)) begin
      errors++;
      $display("FAIL %s counters: got p%0d f%0d t%0d expected p%0d f%0d t%0d",
               tag, pass_cnt, fail_cnt, tmo_cnt, ep, ef, et);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL %s end_flags: got busy=%b done=%b expected busy=0 done=1",
                         tag, busy, done);
    end
    if (n_exp > 0) begin
      checks++;
      if (result_code !== e_code[n_exp-1] || result_data !== e_data[n_exp-1]) begin
        errors++; $display("FAIL %s held_result: got %b/%h expected %b/%h", tag, result_code,
                           result_data, e_code[n_exp-1], e_data[n_exp-1]);
      end
    end
  endtask

  task automatic clear_plan;
    for (int i = 0; i < N; i++) begin
      wr_cyc[i] = -1; wr_dat[i] = 32'd1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; test_mask = '0; timeout_cycles = '0;
    dmem_we = 1'b0; dmem_addr = '0; dmem_wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (core_rst_n !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || result_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got rst_n=%b busy=%b done=%b rv=%b expected all 0",
                         core_rst_n, busy, done, result_valid);
    end
    checks++;
    if ({pass_cnt, fail_cnt, tmo_cnt} !== 9'd0 || test_id !== 2'd0 || boot_pc !== 32'd0) begin
      errors++; $display("FAIL reset_regs: got cnt=%h id=%0d pc=%h expected 0",
                         {pass_cnt, fail_cnt, tmo_cnt}, test_id, boot_pc);
    end
  endtask

  task automatic test_two_pass;
    int c;
    clear_plan();
    wr_cyc[0] = 10; wr_cyc[2] = 10;
    run_campaign("two_pass", 4'b0101, 16'd100, -1, 2000, c);
  endtask

  task automatic test_timeout;
    int c;
    clear_plan();
    run_campaign("timeout", 4'b0010, 16'd50, -1, 2000, c);
  endtask

  task automatic test_write_beats_timeout;
    int c;
    clear_plan();
    wr_cyc[0] = 29; wr_dat[0] = 32'h7;
    run_campaign("write_vs_tmo", 4'b0001, 16'd30, -1, 2000, c);
  endtask

  task automatic test_empty_mask;
    int c;
    clear_plan();
    run_campaign("empty", 4'b0000, 16'd10, -1, 50, c);
    checks++;
    if (c + 1 > N + 1) begin
      errors++; $display("FAIL empty_latency: got %0d cycles expected <= %0d", c + 1, N + 1);
    end
  endtask

  task automatic test_back_to_back;
    int c;
    clear_plan();
    wr_cyc[0] = 20; wr_cyc[1] = 8; wr_dat[1] = 32'h5;
    run_campaign("start_ignored", 4'b0011, 16'd100, 5, 2000, c);
  endtask

  task automatic test_abort_reset;
    int run_idx;
    int c;
    bit reached;
    bit bad;
    run_idx = -1; reached = 0; bad = 0;
    @(negedge clk);
    test_mask = 4'b0001; timeout_cycles = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (core_rst_n) begin
        run_idx++;
        if (run_idx == 10) begin
          reached = 1;
          break;
        end
      end
      @(negedge clk);
    end
    checks++;
    if (!reached || busy !== 1'b1) begin
      errors++; $display("FAIL abort_reach_run: got reached=%0d busy=%b expected 1/1", reached, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({core_rst_n, busy, done, result_valid, test_id, boot_pc, result_code, result_data,
         pass_cnt, fail_cnt, tmo_cnt} !== '0) begin
      errors++; $display("FAIL abort_outputs: got rst_n=%b busy=%b done=%b rv=%b id=%0d pc=%h expected 0",
                         core_rst_n, busy, done, result_valid, test_id, boot_pc);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (result_valid || core_rst_n || busy) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL abort_quiet: got activity after abort expected none");
    end
    clear_plan();
    wr_cyc[0] = 3;
    run_campaign("rerun", 4'b0001, 16'd0, -1, 500, c);
  endtask

  task automatic test_random;
    int c;
    logic [3:0]  mask;
    logic [15:0] tmo;
    for (int r = 0; r < 6; r++) begin
      mask = 4'($urandom_range(0, 15));
      tmo  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
      for (int i = 0; i < N; i++) begin
        wr_cyc[i] = (tmo != 0 && $urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 60));
        wr_dat[i] = ($urandom_range(0, 1) == 0) ? 32'd1 : $urandom;
      end
      run_campaign($sformatf("rand%0d", r), mask, tmo, -1, 2000, c);
    end
  endtask

  task automatic test_wrap;
    int c;
    clear_plan();
    wr_cyc[0] = 70000;
    run_campaign("wrap", 4'b0001, 16'd0, -1, 80000, c);
  endtask

  initial begin
    test_reset();
    test_two_pass();
    test_timeout();
    test_write_beats_timeout();
    test_empty_mask();
    test_back_to_back();
    test_abort_reset();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
